// File: rtl/replay_writer.sv
// replay_writer: 10-slot replay store with a rotating write pointer.
// Samples land in the slot named by wr_ptr; once all slots hold data the
// block either overwrites the oldest slot (OVERWRITE=1) or stalls (OVERWRITE=0).
// clear drops occupancy bookkeeping but keeps slot data; rst wipes everything.

// One storage slot: data register plus its occupancy bit.
module replay_slot #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q,
    output logic              vld
);

    // Data only moves on a write; clear intentionally leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (we) q <= din;
    end

    // Occupancy: clear wins over a write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      vld <= 1'b0;
        else if (clr) vld <= 1'b0;
        else if (we)  vld <= 1'b1;
    end

endmodule

module replay_writer #(
    parameter bit OVERWRITE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        clear,
    output logic [15:0] q0,
    output logic [15:0] q1,
    output logic [15:0] q2,
    output logic [15:0] q3,
    output logic [15:0] q4,
    output logic [15:0] q5,
    output logic [15:0] q6,
    output logic [15:0] q7,
    output logic [15:0] q8,
    output logic [15:0] q9,
    output logic [9:0]  valid_mask,
    output logic [3:0]  wr_ptr,
    output logic [3:0]  oldest,
    output logic [3:0]  count,
    output logic        full
);

    localparam int DEPTH  = 10;
    localparam int DATA_W = 16;
    localparam int PTR_W  = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d, ptr_inc;
    logic [PTR_W-1:0]             cnt_q, cnt_d;
    logic                         wr_en;
    logic [DEPTH-1:0]             slot_we;
    logic [DEPTH-1:0]             slot_vld;
    logic [DEPTH-1:0][DATA_W-1:0] slot_q;

    // Readiness looks only at registered occupancy, never at din_valid.
    assign full      = (state_q == ST_FULL);
    assign din_ready = OVERWRITE || !full;
    assign wr_en     = din_valid && din_ready && !clear;

    // Pointer wraps 9 -> 0 so it never leaves the slot range.
    assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);

    // Next-state, pointer and count; clear dominates any write.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_EMPTY;
            ptr_d   = '0;
            cnt_d   = '0;
        end else if (wr_en) begin
            ptr_d = ptr_inc;
            case (state_q)
                ST_EMPTY: begin
                    state_d = ST_FILLING;
                    cnt_d   = PTR_W'(1);
                end
                ST_FILLING: begin
                    cnt_d = cnt_q + PTR_W'(1);
                    if (cnt_q == PTR_W'(DEPTH - 1)) state_d = ST_FULL;
                end
                default: begin
                    // Full and overwriting: count pinned at DEPTH.
                    state_d = ST_FULL;
                    cnt_d   = PTR_W'(DEPTH);
                end
            endcase
        end
    end

    // State, pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // One slot per index; only the slot under the pointer is written.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign slot_we[i] = wr_en && (ptr_q == PTR_W'(i));
        replay_slot #(.DATA_W(DATA_W)) u_slot (
            .clk (clk),
            .rst (rst),
            .we  (slot_we[i]),
            .clr (clear),
            .din (din),
            .q   (slot_q[i]),
            .vld (slot_vld[i])
        );
    end

    // While full the next write target is also the oldest sample.
    assign oldest     = full ? ptr_q : '0;
    assign wr_ptr     = ptr_q;
    assign count      = cnt_q;
    assign valid_mask = slot_vld;

    assign q0 = slot_q[0];
    assign q1 = slot_q[1];
    assign q2 = slot_q[2];
    assign q3 = slot_q[3];
    assign q4 = slot_q[4];
    assign q5 = slot_q[5];
    assign q6 = slot_q[6];
    assign q7 = slot_q[7];
    assign q8 = slot_q[8];
    assign q9 = slot_q[9];

endmodule

// File: tb/tb_replay_writer.sv
// Scoreboard bench: one DUT per OVERWRITE setting, shared stimulus, a
// behavioural slot model producing expected snapshots compared after each edge.
module tb_replay_writer;

    typedef struct packed {
        logic [159:0] q;
        logic [9:0]   mask;
        logic [3:0]   wp;
        logic [3:0]   old;
        logic [3:0]   cnt;
        logic         full;
        logic         rdy;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        clear = 1'b0;

    logic [15:0] q_s [2][10];
    logic [9:0]  mask_s [2];
    logic [3:0]  wp_s [2], old_s [2], cnt_s [2];
    logic        full_s [2], rdy_s [2];

    int vec_cnt = 0;
    int err_cnt = 0;

    // Model state, index 0 = stall variant, 1 = overwrite variant
    logic [15:0] m_q [2][10];
    logic [9:0]  m_mask [2];
    int          m_wp [2];
    int          m_cnt [2];
    snap_t       sb [$];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        replay_writer #(.OVERWRITE(d == 1)) u_dut (
            .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
            .din_ready(rdy_s[d]), .clear(clear),
            .q0(q_s[d][0]), .q1(q_s[d][1]), .q2(q_s[d][2]), .q3(q_s[d][3]),
            .q4(q_s[d][4]), .q5(q_s[d][5]), .q6(q_s[d][6]), .q7(q_s[d][7]),
            .q8(q_s[d][8]), .q9(q_s[d][9]),
            .valid_mask(mask_s[d]), .wr_ptr(wp_s[d]), .oldest(old_s[d]),
            .count(cnt_s[d]), .full(full_s[d])
        );
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic snap_t obs_snap(input int d);
        snap_t s;
        for (int i = 0; i < 10; i++) s.q[i*16 +: 16] = q_s[d][i];
        s.mask = mask_s[d]; s.wp = wp_s[d]; s.old = old_s[d];
        s.cnt = cnt_s[d]; s.full = full_s[d]; s.rdy = rdy_s[d];
        return s;
    endfunction

    function automatic snap_t model_snap(input int d);
        snap_t s;
        for (int i = 0; i < 10; i++) s.q[i*16 +: 16] = m_q[d][i];
        s.mask = m_mask[d];
        s.wp   = 4'(m_wp[d]);
        s.cnt  = 4'(m_cnt[d]);
        s.full = (m_cnt[d] == 10);
        s.old  = s.full ? 4'(m_wp[d]) : 4'd0;
        s.rdy  = (d == 1) || !s.full;
        return s;
    endfunction

    task automatic cmp_snap(input string tag, input snap_t o, input snap_t e);
        chk({tag, ".q"},     o.q, e.q);
        chk({tag, ".mask"},  160'(o.mask), 160'(e.mask));
        chk({tag, ".wp"},    160'(o.wp), 160'(e.wp));
        chk({tag, ".old"},   160'(o.old), 160'(e.old));
        chk({tag, ".cnt"},   160'(o.cnt), 160'(e.cnt));
        chk({tag, ".full"},  160'(o.full), 160'(e.full));
        chk({tag, ".rdy"},   160'(o.rdy), 160'(e.rdy));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 10; i++) m_q[d][i] = '0;
            m_mask[d] = '0; m_wp[d] = 0; m_cnt[d] = 0;
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic v, input logic [15:0] d_in, input logic c);
        din = d_in; din_valid = v; clear = c;
        for (int d = 0; d < 2; d++) begin
            bit can_take;
            can_take = (d == 1) || (m_cnt[d] < 10);
            if (c) begin
                m_mask[d] = '0; m_wp[d] = 0; m_cnt[d] = 0;
            end else if (v && can_take) begin
                m_q[d][m_wp[d]]    = d_in;
                m_mask[d][m_wp[d]] = 1'b1;
                m_wp[d]            = (m_wp[d] + 1) % 10;
                if (m_cnt[d] < 10) m_cnt[d]++;
            end
            sb.push_back(model_snap(d));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            snap_t e;
            e = sb.pop_front();
            cmp_snap($sformatf("cyc.d%0d", d), obs_snap(d), e);
        end
        din_valid = 1'b0; clear = 1'b0;
    endtask

    initial begin
        snap_t o;
        model_reset();
        #13;
        // Reset state while rst is held
        for (int d = 0; d < 2; d++) cmp_snap($sformatf("rst.d%0d", d), obs_snap(d), model_snap(d));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill 1000..1009
        for (int i = 0; i < 10; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0);
        for (int d = 0; d < 2; d++) begin
            o = obs_snap(d);
            chk("fill.q0", 160'(o.q[15:0]), 160'(16'h1000));
            chk("fill.q9", 160'(o.q[159:144]), 160'(16'h1009));
            chk("fill.mask", 160'(o.mask), 160'(10'h3FF));
            chk("fill.full", 160'(o.full), 160'(1'b1));
        end

        // Overwrite / stall
        step(1'b1, 16'hABCD, 1'b0);
        o = obs_snap(1);
        chk("wrap.q0", 160'(o.q[15:0]), 160'(16'hABCD));
        chk("wrap.wp", 160'(o.wp), 160'(4'd1));
        chk("wrap.old", 160'(o.old), 160'(4'd1));
        for (int k = 0; k < 3; k++) step(1'b1, 16'hFFFF, 1'b0);
        o = obs_snap(0);
        chk("stall.rdy", 160'(o.rdy), 160'(1'b0));
        chk("stall.q0", 160'(o.q[15:0]), 160'(16'h1000));
        chk("stall.cnt", 160'(o.cnt), 160'(4'd10));

        // Clear, then collision at count=4
        step(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0);
        step(1'b1, 16'h5555, 1'b1);
        for (int d = 0; d < 2; d++) begin
            o = obs_snap(d);
            chk("coll.cnt", 160'(o.cnt), 160'(4'd0));
            chk("coll.q4ne", 160'(o.q[79:64] != 16'h5555), 160'(1'b1));
        end

        // Gaps: alternate valid over 6 cycles
        for (int k = 0; k < 6; k++) step((k % 2) == 0, 16'h0007, 1'b0);
        o = obs_snap(0);
        chk("gap.cnt", 160'(o.cnt), 160'(4'd3));
        chk("gap.wp", 160'(o.wp), 160'(4'd3));

        // Async reset between edges, checked before any edge
        #2; rst = 1'b1; #1;
        model_reset();
        for (int d = 0; d < 2; d++) cmp_snap($sformatf("arst.d%0d", d), obs_snap(d), model_snap(d));
        #2; rst = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 16'h0042, 1'b0);
        o = obs_snap(0);
        chk("arst.q0", 160'(o.q[15:0]), 160'(16'h0042));
        chk("arst.cnt", 160'(o.cnt), 160'(4'd1));

        // Random traffic with occasional clears
        for (int k = 0; k < 60; k++)
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), $urandom_range(0, 19) == 0);

        if (sb.size() != 0) chk("sb.empty", 160'(sb.size()), 160'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
